// File: rtl/vend_pkg.sv
// Shared vending definitions: denominations, their dollar values and the
// change-dispenser state encoding. Also used by the deposit decoder and accumulator.
package vend_pkg;

  typedef enum logic [1:0] {
    DEN_NONE,
    DEN_ONE,
    DEN_FIVE,
    DEN_TEN
  } denom_t;

  localparam int unsigned DEN_ONE_VAL  = 1;
  localparam int unsigned DEN_FIVE_VAL = 5;
  localparam int unsigned DEN_TEN_VAL  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } disp_state_t;

  function automatic int unsigned denom_value(input denom_t denom);
    int unsigned value;
    case (denom)
      DEN_ONE:  value = DEN_ONE_VAL;
      DEN_FIVE: value = DEN_FIVE_VAL;
      DEN_TEN:  value = DEN_TEN_VAL;
      default:  value = 0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/denom_select.sv
// Greedy denomination choice: the largest bill not exceeding the amount,
// together with its dollar value. Purely combinational.
module denom_select
  import vend_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] amount,
  output denom_t           denom,
  output logic [AMT_W-1:0] value
);

  // NOTE: every output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    denom = DEN_NONE;
    if (amount >= AMT_W'(DEN_TEN_VAL)) begin
      denom = DEN_TEN;
    end else if (amount >= AMT_W'(DEN_FIVE_VAL)) begin
      denom = DEN_FIVE;
    end else if (amount != '0) begin
      denom = DEN_ONE;
    end
    value = AMT_W'(denom_value(denom));
  end

endmodule

// File: rtl/change_dispenser.sv
// Turns a change amount into timed $10/$5/$1 dispense pulses, largest bill first,
// then strobes done for one cycle.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             hold,
  output logic             disp_ten,
  output logic             disp_five,
  output logic             disp_one,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] remaining
);

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

  disp_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  denom_t           denom_q, denom_d;
  logic [AMT_W-1:0] value_q, value_d;

  denom_t           sel_denom;
  logic [AMT_W-1:0] sel_value;

  denom_select #(
    .AMT_W (AMT_W)
  ) u_denom_select (
    .amount (remaining_q),
    .denom  (sel_denom),
    .value  (sel_value)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      denom_q     <= DEN_NONE;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      denom_q     <= denom_d;
      value_q     <= value_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    denom_d     = denom_q;
    value_d     = value_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = change_amt;
          state_d     = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else if (!hold) begin
          denom_d = sel_denom;
          value_d = sel_value;
          timer_d = '0;
          state_d = ST_PULSE;
        end
      end

      // Selection guaranteed remaining >= value, so this subtraction cannot wrap.
      ST_PULSE: begin
        if (timer_q == PULSE_LAST) begin
          remaining_d = remaining_q - value_q;
          timer_d     = '0;
          state_d     = ST_GAP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = ST_SELECT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign disp_ten  = (state_q == ST_PULSE) && (denom_q == DEN_TEN);
  assign disp_five = (state_q == ST_PULSE) && (denom_q == DEN_FIVE);
  assign disp_one  = (state_q == ST_PULSE) && (denom_q == DEN_ONE);
  assign busy      = (state_q == ST_SELECT) || (state_q == ST_PULSE) || (state_q == ST_GAP);
  assign done      = (state_q == ST_DONE);
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with PULSE_CYCLES=2, GAP_CYCLES=1:
// cycle-exact traces against hand-written tables plus a per-cycle one-hot monitor.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] change_amt;
  logic       hold;
  logic       disp_ten, disp_five, disp_one;
  logic       busy, done;
  logic [7:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  change_dispenser #(
    .AMT_W        (8),
    .PULSE_CYCLES (2),
    .GAP_CYCLES   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .change_amt (change_amt),
    .hold       (hold),
    .disp_ten   (disp_ten),
    .disp_five  (disp_five),
    .disp_one   (disp_one),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  // Dispense codes: 4 = ten, 2 = five, 1 = one.
  int d27 [22] = '{0,4,4,0, 0,4,4,0, 0,2,2,0, 0,1,1,0, 0,1,1,0, 0,0};
  int r27 [22] = '{27,27,27,17, 17,17,17,7, 7,7,7,2, 2,2,2,1, 1,1,1,0, 0,0};
  int d6  [16] = '{0,2,2,0, 0,0,0,0,0,0, 1,1,0, 0,0,0};
  int r6  [16] = '{6,6,6,1, 1,1,1,1,1,1, 1,1,0, 0,0,0};
  int d12 [16] = '{0,4,4,0, 0,1,1,0, 0,1,1,0, 0,0,0,0};
  int r12 [16] = '{12,12,12,2, 2,2,2,1, 1,1,1,0, 0,0,0,0};
  int d5  [6]  = '{0,2,2,0,0,0};
  int r5  [6]  = '{5,5,5,0,0,0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cyc(input string sc, input int c, input int d, input int r,
                         input bit dn, input bit b);
    check($sformatf("%s c%0d disp", sc, c), {29'd0, disp_ten, disp_five, disp_one}, d);
    check($sformatf("%s c%0d remaining", sc, c), {24'd0, remaining}, r);
    check($sformatf("%s c%0d done", sc, c), {31'd0, done}, {31'd0, dn});
    check($sformatf("%s c%0d busy", sc, c), {31'd0, busy}, {31'd0, b});
  endtask

  task automatic start_op(input logic [7:0] amt);
    start      = 1'b1;
    change_amt = amt;
    tick();
    start      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) check("onehot0 disp", {31'd0, $onehot0({disp_ten, disp_five, disp_one})}, 1);
  end

  initial begin
    int done_c;
    int n_ten, n_five, n_one;
    logic [2:0] prev;

    rst = 1'b1; start = 1'b0; change_amt = '0; hold = 1'b0;
    tick();
    tick();
    check("reset disp", {29'd0, disp_ten, disp_five, disp_one}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset remaining", {24'd0, remaining}, 0);
    mon_en = 1'b1;
    rst = 1'b0;
    tick();

    // Mixed change 27: ten, ten, five, one, one; done in cycle 22.
    start_op(8'd27);
    for (int c = 1; c <= 22; c++) begin
      exp_cyc("mix27", c, d27[c-1], r27[c-1], c == 22, c < 22);
      tick();
    end
    check("mix27 idle busy", {31'd0, busy}, 0);
    check("mix27 idle done", {31'd0, done}, 0);

    // Zero change: SELECT then DONE, no pulses.
    start_op(8'd0);
    exp_cyc("zero", 1, 0, 0, 1'b0, 1'b1);
    tick();
    exp_cyc("zero", 2, 0, 0, 1'b1, 1'b0);
    tick();
    exp_cyc("zero", 3, 0, 0, 1'b0, 1'b0);
    tick();

    // Hold for 5 SELECT cycles after the $5 pulse delays the $1 pulse by 5.
    start_op(8'd6);
    for (int c = 1; c <= 16; c++) begin
      hold = (c >= 5 && c <= 9);
      exp_cyc("hold6", c, d6[c-1], r6[c-1], c == 15, c < 15);
      tick();
    end
    hold = 1'b0;

    // start with 99 during PULSE (c2) and DONE (c14) must be ignored.
    start_op(8'd12);
    for (int c = 1; c <= 16; c++) begin
      start      = (c == 2 || c == 14);
      change_amt = start ? 8'd99 : 8'd12;
      exp_cyc("busy12", c, d12[c-1], r12[c-1], c == 14, c < 14);
      tick();
    end
    start = 1'b0;

    // Reset during the second cycle of a $10 pulse.
    start_op(8'd20);
    tick();
    tick();
    check("rstmid pulse before reset", {29'd0, disp_ten, disp_five, disp_one}, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cyc("rstmid", 0, 0, 0, 1'b0, 1'b0);
    tick();
    exp_cyc("rstmid idle", 0, 0, 0, 1'b0, 1'b0);
    start_op(8'd5);
    for (int c = 1; c <= 6; c++) begin
      exp_cyc("rst5", c, d5[c-1], r5[c-1], c == 6, c < 6);
      tick();
    end

    // Maximum amount 255: 25 tens, 1 five, 0 ones; 26 bills -> done in cycle 106.
    start_op(8'd255);
    done_c = 0; n_ten = 0; n_five = 0; n_one = 0; prev = 3'b000;
    for (int c = 1; c <= 400; c++) begin
      if (disp_ten  && !prev[2]) n_ten++;
      if (disp_five && !prev[1]) n_five++;
      if (disp_one  && !prev[0]) n_one++;
      prev = {disp_ten, disp_five, disp_one};
      if (done) begin
        done_c = c;
        break;
      end
      tick();
    end
    check("max255 done cycle", done_c, 106);
    check("max255 tens", n_ten, 25);
    check("max255 fives", n_five, 1);
    check("max255 ones", n_one, 0);
    check("max255 remaining", {24'd0, remaining}, 0);
    tick();
    check("max255 idle busy", {31'd0, busy}, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Converts a binary change amount into a sequence of timed dispense pulses on three denomination outputs ($10, $5, $1). It uses a greedy, largest-denomination-first order. It sits downstream of the vending accumulator/controller: after a sale, the controller hands over the change owed and waits for `done`. It performs the inverse of deposit decoding, turning a value back into physical bills.

## Interface
Parameters:
- `AMT_W`, 8: width of the change amount; maximum change is 2^AMT_W − 1.
- `PULSE_CYCLES`, 4: cycles each dispense output is held high; must be ≥ 1.
- `GAP_CYCLES`, 2: low cycles after each pulse before the next selection; must be ≥ 1.

Ports:
- `clk`  in  1  system clock. One clock domain; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to dispense `change_amt`; sampled only in IDLE.
- `change_amt`  in  AMT_W  change owed, as a binary dollar count.
- `hold`  in  1  inhibit: blocks starting a new pulse, e.g. when the tray is full.
- `disp_ten`  out  1  $10 dispense pulse.
- `disp_five`  out  1  $5 dispense pulse.
- `disp_one`  out  1  $1 dispense pulse.
- `busy`  out  1  high in SELECT, PULSE and GAP.
- `done`  out  1  one-cycle completion strobe.
- `remaining`  out  AMT_W  change not yet dispensed.

## Operation
State machine has five states: IDLE, SELECT, PULSE, GAP, DONE.
- **IDLE**
  - `start`=1: latch `change_amt` into `remaining`; go to SELECT.
  - Otherwise stay.
- **SELECT** (one cycle minimum)
  - `remaining`==0: go to DONE.
  - Else if `hold`=1: stay in SELECT.
  - Else latch the denomination and go to PULSE:
    - $10 if `remaining` ≥ 10;
    - else $5 if `remaining` ≥ 5;
    - else $1.
- **PULSE**
  - The latched denomination output is high for exactly PULSE_CYCLES cycles.
  - On the last of those cycles, `remaining` -= value (10, 5 or 1); go to GAP.
  - `hold` is ignored here; a pulse in progress always completes.
- **GAP**
  - All dispense outputs low for GAP_CYCLES cycles; then go to SELECT.
- **DONE**
  - `done`=1 and `busy`=0 for one cycle; then go to IDLE.

Rules:
- At most one dispense output is high in any cycle.
- Subtraction never underflows, because selection guarantees `remaining` ≥ value. No borrow logic and no error output.
- `start` is ignored outside IDLE, including in DONE. `change_amt` is not re-sampled mid-operation.
- `start` with `change_amt`=0 goes IDLE → SELECT → DONE, with no pulses.
- Reset, including mid-pulse: state IDLE, all outputs 0, `remaining`=0, timers cleared. No partial amount is retained.

## Timing
- Reset values: `disp_ten`=`disp_five`=`disp_one`=0, `busy`=0, `done`=0, `remaining`=0.
- All outputs are registered or decoded from registered state; there are no combinational paths from input to output.
- `start` is sampled at edge 0. `busy` rises in cycle 1 (SELECT). The first pulse is high in cycles 2 … PULSE_CYCLES+1.
- Each bill costs 1 + PULSE_CYCLES + GAP_CYCLES cycles, assuming `hold`=0.
- The total for N bills is 1 + N·(1+P+G) cycles to the final SELECT. `done` is high in the following cycle.
- `remaining` updates on the edge ending the last PULSE cycle. It is visible from the first GAP cycle.
- `hold` asserted in SELECT adds one cycle per cycle it is held. Deasserting `hold` lets PULSE begin on the next cycle.

## Structure
- Shared package `vend_pkg` holds:
  - `denom_t` enum: DEN_NONE, DEN_ONE, DEN_FIVE, DEN_TEN;
  - value constants DEN_ONE_VAL=1, DEN_FIVE_VAL=5, DEN_TEN_VAL=10;
  - `disp_state_t` enum for the five states.
- The `vend_pkg` constants are shared with the deposit decoder and accumulator.
- One sub-module is natural: `denom_select`, purely combinational greedy selection. It maps `remaining` to `denom_t` and its value.
- The FSM and a single shared timer counter, sized for max(PULSE_CYCLES, GAP_CYCLES), stay in `change_dispenser`.

## Test plan
All scenarios use P=2 and G=1 unless stated.
- **Mixed change:** reset, then `start` with `change_amt`=27 → pulses in the order ten, ten, five, one, one. Each pulse is exactly 2 cycles high, with 1 low cycle between pulses. `remaining` steps 27 → 17 → 7 → 2 → 1 → 0. `done` is high in cycle 22 only.
- **Zero change:** `start` with `change_amt`=0 → no dispense pulses. `busy` is high in cycle 1 only, `done` is high in cycle 2, then IDLE.
- **Hold:** `change_amt`=6 with `hold`=1 for 5 cycles after the $5 pulse → the $1 pulse is delayed by exactly 5 cycles. The $5 pulse is unaffected. `remaining` stays at 1 during the hold.
- **Start while busy:** `start` pulsed with `change_amt`=99 during PULSE and during DONE → ignored. The original sequence completes unchanged.
- **Reset mid-operation:** reset asserted in the 2nd cycle of a $10 pulse → next cycle all outputs 0, `remaining`=0, IDLE. A following `start` with 5 gives a single clean $5 pulse.
- **Maximum amount and pulse exclusivity:** with AMT_W=8, `change_amt`=255 → 25 tens, 1 five, 0 ones, then `done`. The bench asserts one-hot-or-zero on the dispense outputs every cycle.
